// File: rtl/regfile_mp_sb.sv
// rtl/regfile_mp_sb.sv - multi-port register file with write-first bypass and writeback scoreboard
module regfile_mp_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]            rd_busy_o,
  input  logic [NUM_WR-1:0]            wr_en_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
  input  logic                         iss_en_i,
  input  logic [ADDR_WIDTH-1:0]        iss_addr_i,
  input  logic                         flush_i
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic [NUM_RD-1:0]     rd_in_range;

  // Next-state storage and scoreboard. Later ports overwrite earlier ones so the
  // highest-index writer wins; issue is applied after writeback so a same-cycle
  // issue leaves the register busy; flush overrides everything.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w]) begin
        for (int r = 1; r < NUM_REGS; r++) begin
          if (wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
            regs_d[r] = wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
            busy_d[r] = 1'b0;
          end
        end
      end
    end
    if (iss_en_i) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (iss_addr_i == ADDR_WIDTH'(r)) begin
          busy_d[r] = 1'b1;
        end
      end
    end
    if (flush_i) begin
      busy_d = '0;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // State registers, cleared asynchronously so no register ever holds X.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // Read ports: stored value, then write-first bypass from the highest matching
  // writer. Busy comes from the registered scoreboard only and is never bypassed.
  // Register 0 always holds zero, so the stored path covers x0 directly.
  always_comb begin
    rd_data_o   = '0;
    rd_busy_o   = '0;
    rd_in_range = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
          rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
          rd_busy_o[p]                          = busy_q[r];
          rd_in_range[p]                        = (r != 0);
        end
      end
      for (int w = 0; w < NUM_WR; w++) begin
        if (rd_in_range[p] && wr_en_i[w] &&
            (wr_addr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
          rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (rst_i) begin
        rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = '0;
        rd_busy_o[p]                          = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb/tb_regfile_mp_sb.sv - directed self-checking bench for regfile_mp_sb
module tb_regfile_mp_sb;

  logic        clk_i;
  logic        rst_i;
  logic [9:0]  rd_addr_i;
  logic [63:0] rd_data_o;
  logic [1:0]  rd_busy_o;
  logic [1:0]  wr_en_i;
  logic [9:0]  wr_addr_i;
  logic [63:0] wr_data_i;
  logic        iss_en_i;
  logic [4:0]  iss_addr_i;
  logic        flush_i;

  int n_asserts;
  int n_fail;

  regfile_mp_sb dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .flush_i    (flush_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_en_i  = 2'b00;
    iss_en_i = 1'b0;
    flush_i  = 1'b0;
  endtask

  initial begin
    n_asserts  = 0;
    n_fail     = 0;
    rst_i      = 1'b1;
    rd_addr_i  = '0;
    wr_en_i    = '0;
    wr_addr_i  = '0;
    wr_data_i  = '0;
    iss_en_i   = 1'b0;
    iss_addr_i = '0;
    flush_i    = 1'b0;
    #2;

    // reset state
    rd_addr_i = {5'd5, 5'd3};
    #1;
    chk("reset_rd0", rd_data_o[31:0], 32'h0);
    chk("reset_rd1", rd_data_o[63:32], 32'h0);
    chk("reset_busy", {30'd0, rd_busy_o}, 32'h0);
    tick();
    rst_i = 1'b0;
    tick();

    // x5 = DEADBEEF with a same-cycle issue of x5 (busy must end at 1)
    wr_en_i    = 2'b01;
    wr_addr_i  = {5'd0, 5'd5};
    wr_data_i  = {32'h0, 32'hDEADBEEF};
    iss_en_i   = 1'b1;
    iss_addr_i = 5'd5;
    tick();
    idle();
    rd_addr_i = {5'd0, 5'd5};
    #1;
    chk("x5_written", rd_data_o[31:0], 32'hDEADBEEF);
    chk("x5_busy_iss_wb", {31'd0, rd_busy_o[0]}, 32'h1);

    // asynchronous reset mid-run
    rst_i = 1'b1;
    #1;
    chk("async_rst_data", rd_data_o[31:0], 32'h0);
    chk("async_rst_busy", {31'd0, rd_busy_o[0]}, 32'h0);
    tick();
    rst_i = 1'b0;
    #1;
    chk("post_rst_x5", rd_data_o[31:0], 32'h0);
    chk("post_rst_busy", {31'd0, rd_busy_o[0]}, 32'h0);

    // basic write/read and x0 discard
    wr_en_i   = 2'b01;
    wr_addr_i = {5'd0, 5'd3};
    wr_data_i = {32'h0, 32'h12345678};
    tick();
    idle();
    rd_addr_i = {5'd3, 5'd0};
    #1;
    chk("x3_port1", rd_data_o[63:32], 32'h12345678);
    wr_en_i   = 2'b01;
    wr_addr_i = {5'd0, 5'd0};
    wr_data_i = {32'h0, 32'hFFFFFFFF};
    #1;
    chk("x0_no_bypass", rd_data_o[31:0], 32'h0);
    tick();
    idle();
    #1;
    chk("x0_stays_zero", rd_data_o[31:0], 32'h0);

    // same-address conflict: port1 wins
    wr_en_i   = 2'b11;
    wr_addr_i = {5'd7, 5'd7};
    wr_data_i = {32'h5555FFFF, 32'hAAAA0000};
    rd_addr_i = {5'd0, 5'd7};
    #1;
    chk("conflict_bypass", rd_data_o[31:0], 32'h5555FFFF);
    tick();
    idle();
    rd_addr_i = {5'd7, 5'd7};
    #1;
    chk("conflict_stored0", rd_data_o[31:0], 32'h5555FFFF);
    chk("conflict_stored1", rd_data_o[63:32], 32'h5555FFFF);

    // bypass: x9 = 1, x10 = ABC, then write x9 = 22 while reading
    wr_en_i   = 2'b11;
    wr_addr_i = {5'd10, 5'd9};
    wr_data_i = {32'h00000ABC, 32'h00000001};
    tick();
    idle();
    rd_addr_i = {5'd10, 5'd9};
    #1;
    chk("x9_before", rd_data_o[31:0], 32'h1);
    chk("x10_not_busy", {31'd0, rd_busy_o[1]}, 32'h0);
    wr_en_i   = 2'b01;
    wr_addr_i = {5'd0, 5'd9};
    wr_data_i = {32'h0, 32'h00000022};
    #1;
    chk("x9_bypass", rd_data_o[31:0], 32'h22);
    chk("x10_unaffected", rd_data_o[63:32], 32'hABC);
    tick();
    idle();
    #1;
    chk("x9_stored", rd_data_o[31:0], 32'h22);

    // scoreboard
    iss_en_i   = 1'b1;
    iss_addr_i = 5'd4;
    rd_addr_i  = {5'd0, 5'd4};
    #1;
    chk("x4_busy_not_early", {31'd0, rd_busy_o[0]}, 32'h0);
    tick();
    idle();
    #1;
    chk("x4_busy_set", {31'd0, rd_busy_o[0]}, 32'h1);
    wr_en_i    = 2'b10;
    wr_addr_i  = {5'd4, 5'd0};
    wr_data_i  = {32'h00000044, 32'h0};
    iss_en_i   = 1'b1;
    iss_addr_i = 5'd4;
    #1;
    chk("x4_busy_not_hidden", {31'd0, rd_busy_o[0]}, 32'h1);
    tick();
    idle();
    #1;
    chk("x4_busy_reissue", {31'd0, rd_busy_o[0]}, 32'h1);
    wr_en_i   = 2'b01;
    wr_addr_i = {5'd0, 5'd4};
    wr_data_i = {32'h0, 32'h00000045};
    tick();
    idle();
    #1;
    chk("x4_busy_cleared", {31'd0, rd_busy_o[0]}, 32'h0);
    chk("x4_data", rd_data_o[31:0], 32'h45);

    // flush
    iss_en_i = 1'b1;
    iss_addr_i = 5'd1;
    tick();
    iss_addr_i = 5'd2;
    tick();
    iss_addr_i = 5'd3;
    tick();
    idle();
    rd_addr_i = {5'd3, 5'd1};
    #1;
    chk("x1_busy", {31'd0, rd_busy_o[0]}, 32'h1);
    chk("x3_busy", {31'd0, rd_busy_o[1]}, 32'h1);
    flush_i    = 1'b1;
    iss_en_i   = 1'b1;
    iss_addr_i = 5'd6;
    tick();
    idle();
    #1;
    chk("flush_x1", {31'd0, rd_busy_o[0]}, 32'h0);
    chk("flush_x3", {31'd0, rd_busy_o[1]}, 32'h0);
    rd_addr_i = {5'd6, 5'd2};
    #1;
    chk("flush_x2", {31'd0, rd_busy_o[0]}, 32'h0);
    chk("flush_x6", {31'd0, rd_busy_o[1]}, 32'h0);

    // issue to x0 never marks busy
    iss_en_i   = 1'b1;
    iss_addr_i = 5'd0;
    tick();
    idle();
    rd_addr_i = {5'd0, 5'd0};
    #1;
    chk("x0_busy", {31'd0, rd_busy_o[0]}, 32'h0);
    chk("x0_data", rd_data_o[31:0], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
